regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Schedules all traffic on the register file's single write port and tracks pending writes for the issue stage. Two writeback requesters compete for the write port: the ALU result path and the data-memory load path. Each uses a valid/ready handshake. A per-register pending-write scoreboard stalls issue on RAW/WAW hazards until the register file has actually been written. Sits between execute/memory stages and the register file; rf_* outputs drive the register file's we/d/dval inputs directly.

Parameters:
NUM_REGISTERS, 32, number of architectural registers. r0 is hard-wired zero. Source index 32 selects pc.
DATA_W, 32, writeback data width.

Ports:
clk  in  1  system clock. The register file writes on negedge; this block updates on posedge.
rst  in  1  asynchronous, active-high reset.
alu_valid  in  1  ALU writeback request.
alu_ready  out  1  ALU request accepted this cycle (combinational).
alu_d  in  5  ALU destination register.
alu_val  in  32  ALU result.
mem_valid  in  1  load writeback request.
mem_ready  out  1  load request accepted this cycle (combinational).
mem_d  in  5  load destination register.
mem_val  in  32  load data.
issue_valid  in  1  instruction presented at issue.
issue_s1  in  6  source 1 index, regfile encoding (0 = zero, 32 = pc).
issue_s2  in  6  source 2 index, same encoding.
issue_d  in  5  destination; 0 means no write.
issue_stall  out  1  hazard; the instruction must not issue this cycle (combinational).
rf_we  out  1  register-file write enable (registered).
rf_d  out  5  register-file destination (registered).
rf_dval  out  32  register-file write data (registered).
idle  out  1  no pending writes and rf_we low.

Behaviour:
Reset (asynchronous, rst=1):
- rf_we=0, rf_d=0, rf_dval=0.
- pend[31:0]=0, rr_last=0 (0 = ALU granted last).
Arbitration (combinational):
- Only one valid: that requester gets ready=1.
- Both valid: grant goes to the requester not named by rr_last. After reset the first tie goes to mem.
- Never assert both readies.
- Loser holds valid/d/val stable; it wins next cycle if still contending.
- rr_last updates only on a tie-resolved grant.
Transfer (valid && ready at posedge):
- rf_d <= d, rf_dval <= val.
- rf_we <= (d != 0). A d=0 transfer completes the handshake with no write.
- No transfer: rf_we <= 0; rf_d/rf_dval hold.
- Latency: accept edge -> rf_we high for exactly one cycle -> register file writes at the following negedge.
Scoreboard:
- Hazard index: s==0 or s==32 -> none. Otherwise index = s[4:0], so 33..63 alias as in the register file.
- issue_stall = issue_valid && (pend[idx(s1)] | pend[idx(s2)] | pend[issue_d]).
- Set: at posedge, if issue_valid && !issue_stall && issue_d!=0 -> pend[issue_d] <= 1.
- Clear: at posedge, if rf_we==1 -> pend[rf_d] <= 0. Stall therefore drops the cycle after the write cycle, when the register file already holds the new value.
- Simultaneous set and clear of the same index: set wins.
- pend[0] is never set.
- Writeback to a non-pending register: written normally; the clear is a no-op.
idle = (pend==0) && !rf_we.
Reset mid-operation: pending writes are discarded. Requesters must re-present after rst falls.

Decomposition:
- Shared package: REG_ZERO=0, REG_PC=32, the index width constants (5/6) and DATA_W. The register file uses the same constants.
- One natural sub-module: regfile_scoreboard (pend vector, set/clear, hazard lookup).
- The arbiter and output register stay in the top module.

Test Plan:
- Reset, then alu_valid with d=5, val=0x1234 -> alu_ready=1; next cycle rf_we=1, rf_d=5, rf_dval=0x1234; the cycle after, rf_we=0.
- alu(d=3) and mem(d=4) valid together for 2 cycles after reset -> mem granted first (rf_d=4), ALU second (rf_d=3). A third tie goes to mem.
- Issue d=7, then issue s1=7 -> stall=1 until the cycle after rf_we with rf_d=7; stall=0 in that next cycle and the register file reads the new value.
- Issue s1=0, s2=32, d=0 with all pend set -> stall=0; issue s1=39 with pend[7]=1 -> stall=1.
- Same edge: rf_we for d=9 and a non-stalled issue with d=9 -> pend[9]=1 afterwards.
- mem_valid with d=0 -> mem_ready=1, rf_we stays 0. Assert rst mid-transfer -> rf_we=0, idle=1 immediately.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_pkg
// Description : Shared register-file encoding constants and hazard helper used
//               by the writeback scheduler and the register file itself.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_scheduler_pkg;

  // Destination index width (r0..r31) and source index width (adds pc).
  localparam int REG_IDX_W = 5;
  localparam int SRC_IDX_W = 6;
  localparam int DATA_W    = 32;

  // Source encodings that never carry a register hazard.
  localparam logic [SRC_IDX_W-1:0] REG_ZERO = 6'd0;
  localparam logic [SRC_IDX_W-1:0] REG_PC   = 6'd32;

  // True when a source index names a real, writable register. Indices 33..63
  // alias onto r1..r31 through their low bits, exactly as the register file.
  function automatic logic src_is_reg(input logic [SRC_IDX_W-1:0] s);
    return (s != REG_ZERO) && (s != REG_PC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_if
// Description : Writeback requester handshakes (ALU, load) plus the issue-stage
//               hazard query, bundled for the writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 32
);
  // ALU writeback request
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_d;
  logic [DATA_W-1:0] alu_val;
  // Load writeback request
  logic              mem_valid;
  logic              mem_ready;
  logic [4:0]        mem_d;
  logic [DATA_W-1:0] mem_val;
  // Issue-stage hazard query
  logic              issue_valid;
  logic [5:0]        issue_s1;
  logic [5:0]        issue_s2;
  logic [4:0]        issue_d;
  logic              issue_stall;

  // Pipeline side: presents requests and instructions.
  modport master (
    output alu_valid, alu_d, alu_val,
    output mem_valid, mem_d, mem_val,
    output issue_valid, issue_s1, issue_s2, issue_d,
    input  alu_ready, mem_ready, issue_stall
  );

  // Scheduler side: grants requests and reports hazards.
  modport slave (
    input  alu_valid, alu_d, alu_val,
    input  mem_valid, mem_d, mem_val,
    input  issue_valid, issue_s1, issue_s2, issue_d,
    output alu_ready, mem_ready, issue_stall
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write bits. Set when a writing
//               instruction issues, cleared when the register file write
//               happens; stalls issue on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int NUM_REGISTERS = 32
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_issue_valid,
  input  wire logic [5:0] i_issue_s1,
  input  wire logic [5:0] i_issue_s2,
  input  wire logic [4:0] i_issue_d,
  input  wire logic       i_clr_en,
  input  wire logic [4:0] i_clr_d,
  output logic            o_stall,
  output logic            o_empty
);
  import regfile_wb_scheduler_pkg::*;

  logic [NUM_REGISTERS-1:0] r_pend;
  logic [NUM_REGISTERS-1:0] w_pend_next;
  logic                     w_hit_s1;
  logic                     w_hit_s2;
  logic                     w_hit_d;
  logic                     w_set;

  // Hazard lookup and next pending vector; set is applied after clear so a
  // same-index set/clear on one edge leaves the bit set.
  always_comb begin
    w_hit_s1 = src_is_reg(i_issue_s1) && r_pend[i_issue_s1[REG_IDX_W-1:0]];
    w_hit_s2 = src_is_reg(i_issue_s2) && r_pend[i_issue_s2[REG_IDX_W-1:0]];
    w_hit_d  = r_pend[i_issue_d];
    o_stall  = i_issue_valid && (w_hit_s1 || w_hit_s2 || w_hit_d);
    w_set    = i_issue_valid && !o_stall && (i_issue_d != '0);
    w_pend_next = r_pend;
    if (i_clr_en) begin
      w_pend_next[i_clr_d] = 1'b0;
    end
    if (w_set) begin
      w_pend_next[i_issue_d] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
    o_empty = (r_pend == '0);
  end

  // Pending-write state; reset discards all outstanding writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Round-robin arbitration of ALU and load writebacks onto the
//               single register-file write port, with a registered write
//               stage and a pending-write scoreboard for the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int NUM_REGISTERS = 32,
  parameter int DATA_W        = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  regfile_wb_scheduler_if.slave      bus,
  output logic                       o_rf_we,
  output logic [4:0]                 o_rf_d,
  output logic [DATA_W-1:0]          o_rf_dval,
  output logic                       o_idle
);
  import regfile_wb_scheduler_pkg::*;

  logic r_rr_last;    // 1 = load path won the most recent tie
  logic w_tie;
  logic w_grant_alu;
  logic w_grant_mem;
  logic w_stall;
  logic w_sb_empty;

  // Grant: a lone requester always wins; on a tie the side not named by
  // r_rr_last wins, so the first tie after reset goes to the load path.
  always_comb begin
    w_tie       = bus.alu_valid && bus.mem_valid;
    w_grant_mem = bus.mem_valid && (!bus.alu_valid || !r_rr_last);
    w_grant_alu = bus.alu_valid && !w_grant_mem;
  end

  assign bus.alu_ready   = w_grant_alu;
  assign bus.mem_ready   = w_grant_mem;
  assign bus.issue_stall = w_stall;

  // Write-port register: one-cycle rf_we pulse per accepted nonzero
  // destination; a d=0 transfer completes the handshake without writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rf_we   <= 1'b0;
      o_rf_d    <= '0;
      o_rf_dval <= '0;
      r_rr_last <= 1'b0;
    end else begin
      if (w_grant_alu) begin
        o_rf_we   <= (bus.alu_d != '0);
        o_rf_d    <= bus.alu_d;
        o_rf_dval <= bus.alu_val;
      end else if (w_grant_mem) begin
        o_rf_we   <= (bus.mem_d != '0);
        o_rf_d    <= bus.mem_d;
        o_rf_dval <= bus.mem_val;
      end else begin
        o_rf_we   <= 1'b0;
      end
      if (w_tie) begin
        r_rr_last <= w_grant_mem;
      end
    end
  end

  // Clearing on the registered write means the stall drops only once the
  // register file has been written at the preceding negedge.
  regfile_scoreboard #(
    .NUM_REGISTERS (NUM_REGISTERS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_issue_valid (bus.issue_valid),
    .i_issue_s1    (bus.issue_s1),
    .i_issue_s2    (bus.issue_s2),
    .i_issue_d     (bus.issue_d),
    .i_clr_en      (o_rf_we),
    .i_clr_d       (o_rf_d),
    .o_stall       (w_stall),
    .o_empty       (w_sb_empty)
  );

  assign o_idle = w_sb_empty && !o_rf_we;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler. Expected writes
//               are queued when a request is presented and popped whenever
//               the register-file write enable is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  typedef struct packed {
    logic [4:0]  d;
    logic [31:0] val;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_we;
  logic [4:0]  rf_d;
  logic [31:0] rf_dval;
  logic        idle;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  regfile_wb_scheduler_if #(.DATA_W(32)) bus ();

  regfile_wb_scheduler #(
    .NUM_REGISTERS (32),
    .DATA_W        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .o_rf_we   (rf_we),
    .o_rf_d    (rf_d),
    .o_rf_dval (rf_dval),
    .o_idle    (idle)
  );

  always #5 clk = ~clk;

  // Every observed register-file write must match the oldest queued one.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got rf_d=%0d rf_dval=%h, expected no write", rf_d, rf_dval);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_d !== mon_e.d || rf_dval !== mon_e.val) begin
          n_fail++;
          $display("FAIL sb_write: got d=%0d val=%h, expected d=%0d val=%h", rf_d, rf_dval, mon_e.d, mon_e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alu_valid   = 1'b0; bus.alu_d = '0; bus.alu_val = '0;
    bus.mem_valid   = 1'b0; bus.mem_d = '0; bus.mem_val = '0;
    bus.issue_valid = 1'b0; bus.issue_s1 = '0; bus.issue_s2 = '0; bus.issue_d = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    n_tests++; if (rf_d !== 5'd0) begin n_fail++; $display("FAIL reset_d: got %0d expected 0", rf_d); end
    n_tests++; if (rf_dval !== 32'd0) begin n_fail++; $display("FAIL reset_dval: got %h expected 0", rf_dval); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
    n_tests++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got alu=%b mem=%b expected 0 0", bus.alu_ready, bus.mem_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_single();
    bus.alu_valid = 1'b1; bus.alu_d = 5'd5; bus.alu_val = 32'h1234;
    #1;
    n_tests++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL alu_ready: got alu=%b mem=%b expected 1 0", bus.alu_ready, bus.mem_ready);
    end
    exp_q.push_back(wr_t'{d: 5'd5, val: 32'h1234});
    tick();
    bus.alu_valid = 1'b0;
    n_tests++; if (rf_we !== 1'b1 || rf_d !== 5'd5 || rf_dval !== 32'h1234) begin
      n_fail++; $display("FAIL alu_write: got we=%b d=%0d val=%h expected 1 5 00001234", rf_we, rf_d, rf_dval);
    end
    tick();
    n_tests++; if (rf_we !== 1'b0 || rf_d !== 5'd5) begin
      n_fail++; $display("FAIL alu_we_pulse: got we=%b d=%0d expected 0 5", rf_we, rf_d);
    end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL alu_idle: got %b expected 1", idle); end
  endtask

  task automatic test_tie();
    // Cycle 1: first tie after reset goes to load path.
    bus.alu_valid = 1'b1; bus.alu_d = 5'd3; bus.alu_val = 32'hA100_0003;
    bus.mem_valid = 1'b1; bus.mem_d = 5'd4; bus.mem_val = 32'hB100_0004;
    #1;
    n_tests++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie1_grant: got alu=%b mem=%b expected 0 1", bus.alu_ready, bus.mem_ready);
    end
    exp_q.push_back(wr_t'{d: 5'd4, val: 32'hB100_0004});
    tick();
    // Cycle 2: ALU still holding, load presents a new request; ALU wins.
    bus.mem_d = 5'd6; bus.mem_val = 32'hC100_0006;
    #1;
    n_tests++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie2_grant: got alu=%b mem=%b expected 1 0", bus.alu_ready, bus.mem_ready);
    end
    n_tests++; if (rf_d !== 5'd4) begin n_fail++; $display("FAIL tie1_rf_d: got %0d expected 4", rf_d); end
    exp_q.push_back(wr_t'{d: 5'd3, val: 32'hA100_0003});
    tick();
    // Cycle 3: third tie goes back to the load path.
    bus.alu_d = 5'd8; bus.alu_val = 32'hD100_0008;
    #1;
    n_tests++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie3_grant: got alu=%b mem=%b expected 0 1", bus.alu_ready, bus.mem_ready);
    end
    n_tests++; if (rf_d !== 5'd3) begin n_fail++; $display("FAIL tie2_rf_d: got %0d expected 3", rf_d); end
    exp_q.push_back(wr_t'{d: 5'd6, val: 32'hC100_0006});
    tick();
    bus.mem_valid = 1'b0;
    #1;
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL tie_loser_wins: got %b expected 1", bus.alu_ready); end
    exp_q.push_back(wr_t'{d: 5'd8, val: 32'hD100_0008});
    tick();
    bus.alu_valid = 1'b0;
    n_tests++; if (rf_we !== 1'b1 || rf_d !== 5'd8) begin
      n_fail++; $display("FAIL tie4_write: got we=%b d=%0d expected 1 8", rf_we, rf_d);
    end
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL tie_we_drop: got %b expected 0", rf_we); end
  endtask

  task automatic test_raw_hazard();
    bus.issue_valid = 1'b1; bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd0; bus.issue_d = 5'd7;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_d7: got %b expected 0", bus.issue_stall); end
    tick();
    bus.issue_s1 = 6'd7; bus.issue_d = 5'd0;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b expected 1", bus.issue_stall); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL raw_not_idle: got %b expected 0", idle); end
    bus.issue_s1 = 6'd39;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL alias_39: got %b expected 1", bus.issue_stall); end
    bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd32;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL zero_pc_src: got %b expected 0", bus.issue_stall); end
    bus.issue_s2 = 6'd0; bus.issue_d = 5'd7;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", bus.issue_stall); end
    bus.issue_s1 = 6'd7; bus.issue_d = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_d = 5'd7; bus.alu_val = 32'hCAFE_0007;
    #1;
    exp_q.push_back(wr_t'{d: 5'd7, val: 32'hCAFE_0007});
    tick();
    bus.alu_valid = 1'b0;
    n_tests++; if (rf_we !== 1'b1 || rf_d !== 5'd7) begin
      n_fail++; $display("FAIL raw_write: got we=%b d=%0d expected 1 7", rf_we, rf_d);
    end
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_in_write_cycle: got %b expected 1", bus.issue_stall); end
    tick();
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_release: got %b expected 0", bus.issue_stall); end
    bus.issue_valid = 1'b0; bus.issue_s1 = 6'd0;
    tick();
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL raw_idle: got %b expected 1", idle); end
  endtask

  task automatic test_all_pending();
    int stall_errs = 0;
    int ready_errs = 0;
    for (int k = 1; k < 32; k++) begin
      bus.issue_valid = 1'b1; bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd0; bus.issue_d = 5'(k);
      #1;
      if (bus.issue_stall !== 1'b0) stall_errs++;
      tick();
    end
    n_tests++; if (stall_errs != 0) begin n_fail++; $display("FAIL fill_no_stall: got %0d stalls expected 0", stall_errs); end
    bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd32; bus.issue_d = 5'd0;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL allpend_zero_pc: got %b expected 0", bus.issue_stall); end
    bus.issue_s1 = 6'd39; bus.issue_s2 = 6'd0;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL allpend_s1_39: got %b expected 1", bus.issue_stall); end
    bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd63;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL allpend_s2_63: got %b expected 1", bus.issue_stall); end
    bus.issue_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL stall_needs_valid: got %b expected 0", bus.issue_stall); end
    bus.issue_s2 = 6'd0;
    for (int k = 1; k < 32; k++) begin
      bus.alu_valid = 1'b1; bus.alu_d = 5'(k); bus.alu_val = 32'hA000_0000 | 32'(k);
      #1;
      if (bus.alu_ready !== 1'b1) ready_errs++;
      exp_q.push_back(wr_t'{d: 5'(k), val: 32'hA000_0000 | 32'(k)});
      tick();
    end
    bus.alu_valid = 1'b0;
    n_tests++; if (ready_errs != 0) begin n_fail++; $display("FAIL drain_ready: got %0d misses expected 0", ready_errs); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL drain_last_pending: got idle=%b expected 0", idle); end
    tick();
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got %b expected 1", idle); end
  endtask

  task automatic test_same_edge();
    bus.alu_valid = 1'b1; bus.alu_d = 5'd9; bus.alu_val = 32'h0900_0001;
    #1;
    exp_q.push_back(wr_t'{d: 5'd9, val: 32'h0900_0001});
    tick();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd0; bus.issue_d = 5'd9;
    #1;
    n_tests++; if (rf_we !== 1'b1 || rf_d !== 5'd9 || bus.issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL same_edge_setup: got we=%b d=%0d stall=%b expected 1 9 0", rf_we, rf_d, bus.issue_stall);
    end
    tick();
    bus.issue_s1 = 6'd9; bus.issue_d = 5'd0;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL same_edge_set_wins: got %b expected 1", bus.issue_stall); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL same_edge_pending: got idle=%b expected 0", idle); end
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_val = 32'h0900_0002;
    #1;
    exp_q.push_back(wr_t'{d: 5'd9, val: 32'h0900_0002});
    tick();
    bus.alu_valid = 1'b0;
    tick();
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL same_edge_cleared: got idle=%b expected 1", idle); end
  endtask

  task automatic test_zero_dest();
    bus.mem_valid = 1'b1; bus.mem_d = 5'd0; bus.mem_val = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL zero_d_ready: got %b expected 1", bus.mem_ready); end
    tick();
    bus.mem_valid = 1'b0;
    n_tests++; if (rf_we !== 1'b0 || rf_d !== 5'd0 || rf_dval !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL zero_d_nowrite: got we=%b d=%0d val=%h expected 0 0 deadbeef", rf_we, rf_d, rf_dval);
    end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL zero_d_idle: got %b expected 1", idle); end
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1'b1; bus.issue_s1 = 6'd0; bus.issue_s2 = 6'd0; bus.issue_d = 5'd12;
    #1;
    tick();
    bus.issue_valid = 1'b0; bus.issue_d = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_d = 5'd12; bus.alu_val = 32'h1200_0012;
    #1;
    tick();
    bus.alu_valid = 1'b0;
    n_tests++; if (rf_we !== 1'b1 || idle !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pre: got we=%b idle=%b expected 1 0", rf_we, idle);
    end
    rst = 1'b1;
    #1;
    n_tests++; if (rf_we !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: got we=%b idle=%b expected 0 1", rf_we, idle);
    end
    n_tests++; if (rf_d !== 5'd0 || rf_dval !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_regs: got d=%0d val=%h expected 0 0", rf_d, rf_dval);
    end
    tick();
    rst = 1'b0;
    tick();
    bus.issue_valid = 1'b1; bus.issue_s1 = 6'd12;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: got %b expected 0", bus.issue_stall); end
    bus.issue_valid = 1'b0; bus.issue_s1 = 6'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_tie();
    test_raw_hazard();
    test_all_pending();
    test_same_edge();
    test_zero_dest();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d writes outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
